// File: rtl/spi_reg_arbiter.sv
// Round-robin write arbiter and commit controller for the config register bank.
// Shares reg0..reg4 between the SPI write port (A) and the config sequencer (B).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   a_req/a_addr/a_data port A write request, held until a_gnt
//   a_gnt               one-cycle grant pulse to port A
//   b_req/b_addr/b_data port B write request, held until b_gnt
//   b_gnt               one-cycle grant pulse to port B
//   err_clr             clears err_flag and err_cnt
//   reg_out0..reg_out4  committed register contents
//   wr_stb              one-cycle pulse when a valid write commits
//   wr_addr             address of the current grant
//   err_flag            sticky rejected-write flag
//   err_cnt             saturating rejected-write count
module spi_reg_arbiter #(
    parameter int NUM_REGS  = 5,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_req,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_data,
    output logic                 a_gnt,

    input  logic                 b_req,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 b_gnt,

    input  logic                 err_clr,

    output logic [DATA_W-1:0]    reg_out0,
    output logic [DATA_W-1:0]    reg_out1,
    output logic [DATA_W-1:0]    reg_out2,
    output logic [DATA_W-1:0]    reg_out3,
    output logic [DATA_W-1:0]    reg_out4,

    output logic                 wr_stb,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS);

    state_t              state_q;
    state_t              state_d;

    // rr_q: 0 = port A has priority on a tie, 1 = port B
    logic                rr_q;
    // win_q: port that owns the latched request (0 = A, 1 = B)
    logic                win_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                take;
    logic                sel_b;
    logic                reject;
    logic                in_range;

    assign in_range = (addr_q < ADDR_LIMIT);

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        sel_b   = 1'b0;
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        wr_stb  = 1'b0;
        reject  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    take    = 1'b1;
                    // B wins when alone, or on a tie when it holds priority
                    sel_b   = b_req && (!a_req || rr_q);
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                a_gnt   = !win_q;
                b_gnt   = win_q;
                wr_stb  = in_range;
                reject  = !in_range;
                state_d = IDLE;
            end
        endcase

        // Reset landing on a COMMIT cycle kills the grant and the write
        if (rst) begin
            a_gnt  = 1'b0;
            b_gnt  = 1'b0;
            wr_stb = 1'b0;
            reject = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            win_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                win_q  <= sel_b;
                rr_q   <= ~sel_b;
                addr_q <= sel_b ? b_addr : a_addr;
                data_q <= sel_b ? b_data : a_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_stb) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == ADDR_W'(i)) begin
                    regs_q[i] <= data_q;
                end
            end
        end
    end

    // A clear coinciding with a rejection counts that rejection afresh
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else if (reject) begin
            err_flag <= 1'b1;
            if (err_clr) begin
                err_cnt <= ERR_CNT_W'(1);
            end else if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end
    end

    assign wr_addr  = addr_q;
    assign reg_out0 = regs_q[0];
    assign reg_out1 = regs_q[1];
    assign reg_out2 = regs_q[2];
    assign reg_out3 = regs_q[3];
    assign reg_out4 = regs_q[4];

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed self-checking bench for spi_reg_arbiter.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_spi_reg_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req;
    logic [6:0] a_addr;
    logic [7:0] a_data;
    logic       a_gnt;
    logic       b_req;
    logic [6:0] b_addr;
    logic [7:0] b_data;
    logic       b_gnt;
    logic       err_clr;
    logic [7:0] reg_out0;
    logic [7:0] reg_out1;
    logic [7:0] reg_out2;
    logic [7:0] reg_out3;
    logic [7:0] reg_out4;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic       err_flag;
    logic [3:0] err_cnt;

    int n_chk;
    int n_pass;

    spi_reg_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_gnt    (a_gnt),
        .b_req    (b_req),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_gnt    (b_gnt),
        .err_clr  (err_clr),
        .reg_out0 (reg_out0),
        .reg_out1 (reg_out1),
        .reg_out2 (reg_out2),
        .reg_out3 (reg_out3),
        .reg_out4 (reg_out4),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .err_flag (err_flag),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bad_write_b(input logic [6:0] addr);
        b_req  = 1'b1;
        b_addr = addr;
        b_data = 8'hEE;
        tick;
        b_req = 1'b0;
        tick;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b1;
        a_req   = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_req   = 1'b0;
        b_addr  = '0;
        b_data  = '0;
        err_clr = 1'b0;
        tick;
        tick;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_regs", {reg_out0, reg_out1, reg_out2, reg_out3}, 0);
        chk("rst_reg4", reg_out4, 0);
        rst = 1'b0;

        // 1: single A write to reg2
        a_req  = 1'b1;
        a_addr = 7'd2;
        a_data = 8'hA5;
        #1;
        chk("t1_idle_stb", wr_stb, 0);
        tick;
        chk("t1_a_gnt", a_gnt, 1);
        chk("t1_b_gnt", b_gnt, 0);
        chk("t1_wr_stb", wr_stb, 1);
        chk("t1_wr_addr", wr_addr, 2);
        chk("t1_reg2_old", reg_out2, 0);
        a_req = 1'b0;
        tick;
        chk("t1_reg2", reg_out2, 8'hA5);
        chk("t1_a_gnt_off", a_gnt, 0);
        chk("t1_stb_off", wr_stb, 0);
        chk("t1_others", {reg_out0, reg_out1, reg_out3, reg_out4}, 0);
        chk("t1_err_cnt", err_cnt, 0);

        // 2: simultaneous requests after reset, A has priority
        rst = 1'b1;
        tick;
        rst = 1'b0;
        a_req  = 1'b1;
        a_addr = 7'd0;
        a_data = 8'h11;
        b_req  = 1'b1;
        b_addr = 7'd1;
        b_data = 8'h22;
        tick;
        chk("t2_a_first", a_gnt, 1);
        chk("t2_b_wait", b_gnt, 0);
        chk("t2_wr_addr0", wr_addr, 0);
        a_req = 1'b0;
        tick;
        chk("t2_reg0", reg_out0, 8'h11);
        tick;
        chk("t2_b_gnt", b_gnt, 1);
        chk("t2_wr_addr1", wr_addr, 1);
        chk("t2_b_stb", wr_stb, 1);
        b_req = 1'b0;
        tick;
        chk("t2_reg1", reg_out1, 8'h22);

        // pointer is back at A after B's grant; a lone A write hands it to B
        a_req  = 1'b1;
        a_addr = 7'd0;
        a_data = 8'h33;
        tick;
        a_req = 1'b0;
        tick;
        chk("t2_solo_reg0", reg_out0, 8'h33);
        a_req  = 1'b1;
        a_data = 8'h44;
        b_req  = 1'b1;
        b_data = 8'h55;
        tick;
        chk("t2r_b_first", b_gnt, 1);
        chk("t2r_a_wait", a_gnt, 0);
        chk("t2r_wr_addr", wr_addr, 1);
        b_req = 1'b0;
        tick;
        tick;
        chk("t2r_a_gnt", a_gnt, 1);
        a_req = 1'b0;
        tick;
        chk("t2r_reg0", reg_out0, 8'h44);
        chk("t2r_reg1", reg_out1, 8'h55);

        // 3: rejected writes and saturation
        b_req  = 1'b1;
        b_addr = 7'd5;
        b_data = 8'hFF;
        tick;
        chk("t3_b_gnt", b_gnt, 1);
        chk("t3_no_stb", wr_stb, 0);
        chk("t3_wr_addr", wr_addr, 5);
        b_req = 1'b0;
        tick;
        chk("t3_err_flag", err_flag, 1);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_regs", {reg_out0, reg_out1, reg_out2, reg_out3},
            {8'h44, 8'h55, 8'h00, 8'h00});
        chk("t3_reg4", reg_out4, 0);
        for (int i = 0; i < 16; i++) begin
            bad_write_b((i % 2 == 0) ? 7'd127 : 7'd5);
            if (i == 12) chk("t3_cnt14", err_cnt, 14);
        end
        chk("t3_sat", err_cnt, 15);
        chk("t3_sat_flag", err_flag, 1);

        // 4: clear alone, then clear colliding with a rejection
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("t4_clr_flag", err_flag, 0);
        chk("t4_clr_cnt", err_cnt, 0);
        for (int i = 0; i < 3; i++) bad_write_b(7'd100);
        chk("t4_cnt3", err_cnt, 3);
        b_req  = 1'b1;
        b_addr = 7'd127;
        tick;
        err_clr = 1'b1;
        b_req   = 1'b0;
        tick;
        err_clr = 1'b0;
        chk("t4_both_flag", err_flag, 1);
        chk("t4_both_cnt", err_cnt, 1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("t4_after_flag", err_flag, 0);
        chk("t4_after_cnt", err_cnt, 0);

        // 5: A holds req for six cycles, grants on cycles 2, 4, 6
        a_req  = 1'b1;
        a_addr = 7'd4;
        a_data = 8'h3C;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("t5_gnt_c%0d", c), a_gnt, (c % 2 == 0) ? 1 : 0);
            if (c == 6) a_req = 1'b0;
            tick;
        end
        chk("t5_reg4", reg_out4, 8'h3C);
        tick;
        chk("t5_no_extra", a_gnt, 0);

        // 6: reset during COMMIT; pointer is at B beforehand
        a_req  = 1'b1;
        a_addr = 7'd3;
        a_data = 8'h77;
        tick;
        rst = 1'b1;
        #1;
        chk("t6_no_gnt", a_gnt, 0);
        chk("t6_no_stb", wr_stb, 0);
        a_req = 1'b0;
        tick;
        rst = 1'b0;
        chk("t6_reg3", reg_out3, 0);
        chk("t6_reg4_rst", reg_out4, 0);
        chk("t6_wr_addr", wr_addr, 0);
        a_req  = 1'b1;
        a_addr = 7'd1;
        a_data = 8'h66;
        b_req  = 1'b1;
        b_addr = 7'd2;
        b_data = 8'h99;
        tick;
        chk("t6_a_first", a_gnt, 1);
        chk("t6_b_wait", b_gnt, 0);
        a_req = 1'b0;
        b_req = 1'b0;
        tick;
        chk("t6_reg1", reg_out1, 8'h66);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
